// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared types and constants for the run/halt/step controller
package run_ctrl_pkg;

  // Controller states; the numeric values are visible on state_o
  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_RUN   = 3'd1,
    ST_HALT  = 3'd2,
    ST_ERROR = 3'd3,
    ST_STEP  = 3'd4
  } state_e;

  // Debug command opcodes carried on cmd_i
  typedef enum logic [1:0] {
    CMD_HALT  = 2'b00,
    CMD_RUN   = 2'b01,
    CMD_STEP  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  // Reason for the most recent stop, visible on halt_cause_o
  typedef enum logic [2:0] {
    CAUSE_NONE      = 3'd0,
    CAUSE_ECALL     = 3'd1,
    CAUSE_EBREAK    = 3'd2,
    CAUSE_CMD_HALT  = 3'd3,
    CAUSE_STEP_DONE = 3'd4,
    CAUSE_ERROR     = 3'd5
  } cause_e;

  // Bit positions inside the exception vector
  localparam int ANOMALY_MSB = 2;
  localparam int ECALL       = 3;
  localparam int EBREAK      = 4;

  // A STEP of zero still retires one instruction
  function automatic logic [7:0] step_count_load(input logic [7:0] n);
    return (n == 8'd0) ? 8'd1 : n;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - enabled wrapping event counter with synchronous active-low clear
module perf_counter
  import run_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  clr_ni,
  input  logic                  en_i,
  output logic [DATA_WIDTH-1:0] count_o
);

  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_count;

  // Count enabled cycles; natural overflow wraps all-ones back to zero
  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      r_count <= '0;
    end else if (en_i) begin
      r_count <= r_count + ONE;
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - CPU run/halt/single-step controller with exception handling
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int BOOT_RUN   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            exception_i,
  input  logic                  cmd_valid_i,
  input  logic [1:0]            cmd_i,
  input  logic [7:0]            cmd_arg_i,
  output logic                  cmd_ready_o,
  output logic                  pc_we_o,
  output logic [2:0]            state_o,
  output logic [2:0]            halt_cause_o,
  output logic [2:0]            err_code_o,
  output logic [DATA_WIDTH-1:0] retired_o
);

  state_e     r_state;
  state_e     w_state_nxt;
  cause_e     r_cause;
  cause_e     w_cause_nxt;
  logic [2:0] r_err;
  logic [2:0] w_err_nxt;
  logic [7:0] r_step_cnt;
  logic [7:0] w_step_nxt;

  logic       w_anomaly;
  logic       w_ecall;
  logic       w_ebreak;
  logic       w_exc;
  logic       w_active;
  logic       w_pc_we;
  logic       w_ready;
  logic       w_cmd_acc;
  cmd_e       w_cmd;
  logic       w_last_step;
  logic       w_unused;

  // Upper exception bits carry no meaning for this controller
  assign w_unused = &{1'b0, exception_i[7:5]};

  assign w_anomaly = |exception_i[ANOMALY_MSB:0];
  assign w_ecall   = exception_i[ECALL];
  assign w_ebreak  = exception_i[EBREAK];
  assign w_exc     = w_anomaly | w_ecall | w_ebreak;

  // An instruction retires only while executing and only on a clean cycle
  assign w_active    = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign w_pc_we     = w_active && !w_exc;
  assign w_ready     = (r_state != ST_RST);
  assign w_cmd_acc   = cmd_valid_i && w_ready;
  assign w_cmd       = cmd_e'(cmd_i);
  assign w_last_step = (r_state == ST_STEP) && w_pc_we && (r_step_cnt == 8'd1);

  // State, cause, error code and step budget registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state    <= ST_RST;
      r_cause    <= CAUSE_NONE;
      r_err      <= 3'd0;
      r_step_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cause    <= w_cause_nxt;
      r_err      <= w_err_nxt;
      r_step_cnt <= w_step_nxt;
    end
  end

  // Next-state logic: exceptions beat commands, the final step retire beats HALT
  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    w_err_nxt   = r_err;
    w_step_nxt  = r_step_cnt;
    case (r_state)
      ST_RST: begin
        if (BOOT_RUN != 0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_HALT;
          w_cause_nxt = CAUSE_CMD_HALT;
        end
      end
      ST_RUN, ST_STEP: begin
        if ((r_state == ST_STEP) && w_pc_we) begin
          w_step_nxt = r_step_cnt - 8'd1;
        end
        if (w_anomaly) begin
          w_state_nxt = ST_ERROR;
          w_cause_nxt = CAUSE_ERROR;
          w_err_nxt   = exception_i[ANOMALY_MSB:0];
        end else if (w_ecall) begin
          w_state_nxt = ST_HALT;
          w_cause_nxt = CAUSE_ECALL;
        end else if (w_ebreak) begin
          w_state_nxt = ST_HALT;
          w_cause_nxt = CAUSE_EBREAK;
        end else if (w_last_step) begin
          w_state_nxt = ST_HALT;
          w_cause_nxt = CAUSE_STEP_DONE;
        end else if (w_cmd_acc && (w_cmd == CMD_HALT)) begin
          w_state_nxt = ST_HALT;
          w_cause_nxt = CAUSE_CMD_HALT;
        end
      end
      ST_HALT: begin
        if (w_cmd_acc) begin
          case (w_cmd)
            CMD_RUN: begin
              w_state_nxt = ST_RUN;
              w_cause_nxt = CAUSE_NONE;
            end
            CMD_STEP: begin
              w_state_nxt = ST_STEP;
              w_step_nxt  = step_count_load(cmd_arg_i);
            end
            default: begin
            end
          endcase
        end
      end
      ST_ERROR: begin
        if (w_cmd_acc && (w_cmd == CMD_CLEAR)) begin
          w_state_nxt = ST_HALT;
          w_cause_nxt = CAUSE_NONE;
          w_err_nxt   = 3'd0;
        end
      end
      default: begin
        w_state_nxt = ST_RST;
      end
    endcase
  end

  perf_counter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_retired (
    .clk_i   (clk_i),
    .clr_ni  (rst_i),
    .en_i    (w_pc_we),
    .count_o (retired_o)
  );

  assign cmd_ready_o  = w_ready;
  assign pc_we_o      = w_pc_we;
  assign state_o      = r_state;
  assign halt_cause_o = r_cause;
  assign err_code_o   = r_err;

endmodule
